// File: rtl/frame_scan_streamer_pkg.sv
// Shared types and helpers for the raster-scan pixel streamer.
// Holds frame-size defaults, FSM states, marker bit positions and grey expansion.
package frame_gen_pkg;

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MARK_SOF  = 0;
  localparam int MARK_EOL  = 1;
  localparam int MARK_EOF  = 2;
  localparam int MARK_BITS = 3;

  // Bit replication spreads the 2-bit code evenly over the 8-bit grey range.
  function automatic logic [7:0] grey_decode(input logic [1:0] code);
    return {4{code}};
  endfunction

endpackage

// File: rtl/frame_scan_streamer_if.sv
// Pixel stream bus from the raster-scan streamer to the frame sink.
interface frame_scan_streamer_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       sof;
  logic       eol;
  logic       eof;

  modport master (output data, valid, sof, eol, eof, input ready);
  modport slave  (input data, valid, sof, eol, eof, output ready);

endinterface

// File: rtl/frame_scan_streamer_scan_counter.sv
// Column/row raster counter with enable and clear; flags the last column and last pixel.
module scan_counter
  import frame_gen_pkg::*;
#(
  parameter int frame_width  = FRAME_W,
  parameter int frame_height = FRAME_H
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic        last_x,
  output logic        last_frame
);

  localparam int XW = (frame_width  > 1) ? $clog2(frame_width)  : 1;
  localparam int YW = (frame_height > 1) ? $clog2(frame_height) : 1;

  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic          last_y;

  assign last_x     = (x_reg == XW'(frame_width - 1));
  assign last_y     = (y_reg == YW'(frame_height - 1));
  assign last_frame = last_x && last_y;

  // Wrapping to (0,0) after the final pixel keeps addresses inside the frame.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (enable) begin
      if (last_x) begin
        x_reg <= '0;
        y_reg <= last_y ? '0 : y_reg + YW'(1);
      end else begin
        x_reg <= x_reg + XW'(1);
      end
    end
  end

  assign x = 32'(x_reg);
  assign y = 32'(y_reg);

endmodule

// File: rtl/frame_scan_streamer.sv
// Raster-scan driver: addresses the pixel memory, expands codes to grey and
// emits a valid/ready pixel stream with start/end-of-line/end-of-frame markers.
module frame_scan_streamer
  import frame_gen_pkg::*;
#(
  parameter int frame_width  = FRAME_W,
  parameter int frame_height = FRAME_H
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  pix_x,
  output logic [31:0]                  pix_y,
  input  logic [1:0]                   pix_value,
  frame_scan_streamer_if.master        m
);

  state_t                 state_reg;
  state_t                 state_next;
  logic                   load;
  logic                   clear;
  logic                   last_x;
  logic                   last_frame;
  logic [7:0]             data_reg;
  logic                   valid_reg;
  logic [MARK_BITS-1:0]   mark_reg;
  logic [MARK_BITS-1:0]   mark_next;

  scan_counter #(
    .frame_width  (frame_width),
    .frame_height (frame_height)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .enable     (load),
    .x          (pix_x),
    .y          (pix_y),
    .last_x     (last_x),
    .last_frame (last_frame)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (load && last_frame) state_next = FLUSH;
      FLUSH:   if (valid_reg && m.ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The output register refills whenever it is empty or being drained this cycle.
  always_comb begin
    busy  = (state_reg != IDLE);
    done  = (state_reg == DONE);
    load  = (state_reg == SCAN) && (!valid_reg || m.ready);
    clear = (state_reg == IDLE);
  end

  always_comb begin
    mark_next           = '0;
    mark_next[MARK_SOF] = (pix_x == 32'd0) && (pix_y == 32'd0);
    mark_next[MARK_EOL] = last_x;
    mark_next[MARK_EOF] = last_frame;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      mark_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= grey_decode(pix_value);
      mark_reg  <= mark_next;
      valid_reg <= 1'b1;
    end else if (m.ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign m.data  = data_reg;
  assign m.valid = valid_reg;
  assign m.sof   = mark_reg[MARK_SOF];
  assign m.eol   = mark_reg[MARK_EOL];
  assign m.eof   = mark_reg[MARK_EOF];

endmodule

// File: tb/tb_frame_scan_streamer.sv
// Directed bench for frame_scan_streamer on a 4x3 frame with a behavioural pixel memory.
module tb_frame_scan_streamer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
    int         cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] pix_x;
  logic [31:0] pix_y;
  logic [1:0]  pix_value;

  frame_scan_streamer_if m();

  frame_scan_streamer #(
    .frame_width  (W),
    .frame_height (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_value (pix_value),
    .m         (m)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [N];
  logic [7:0] grey_lut [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
  int         mem_idx;

  always_comb begin
    pix_value = 2'b00;
    mem_idx   = int'(pix_y) * W + int'(pix_x);
    if (pix_x < W && pix_y < H) pix_value = mem[mem_idx];
  end

  int check_count = 0;
  int pass_count  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  bit   rand_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    m.ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int    cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t       q[$];
  beat_t       nb;
  int          done_count = 0;
  int          done_cyc = 0;
  logic        stall_prev = 1'b0;
  logic [7:0]  s_data;
  logic [2:0]  s_mark;
  logic [31:0] s_x;
  logic [31:0] s_y;

  // Beats, done pulses and stall stability are observed mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check_eq("stall_valid", 32'(m.valid), 32'd1);
        check_eq("stall_data", 32'(m.data), 32'(s_data));
        check_eq("stall_mark", 32'({m.sof, m.eol, m.eof}), 32'(s_mark));
        check_eq("stall_x", pix_x, s_x);
        check_eq("stall_y", pix_y, s_y);
      end
      if (m.valid) begin
        check_eq("x_range", 32'(pix_x < W), 32'd1);
        check_eq("y_range", 32'(pix_y < H), 32'd1);
      end
      if (m.valid && m.ready) begin
        nb.data = m.data; nb.sof = m.sof; nb.eol = m.eol; nb.eof = m.eof; nb.cyc = cyc;
        q.push_back(nb);
        $display("beat %0d data=%h sof=%b eol=%b eof=%b cyc=%0d",
                 q.size() - 1, m.data, m.sof, m.eol, m.eof, cyc);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        check_eq("busy_at_done", 32'(busy), 32'd1);
        $display("done pulse %0d cyc=%0d", done_count, cyc);
      end
      stall_prev = m.valid && !m.ready;
      s_data = m.data; s_mark = {m.sof, m.eol, m.eof}; s_x = pix_x; s_y = pix_y;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_count < target && n < budget) begin tick(); n++; end
    if (done_count < target) check_eq({tag, "_done_timeout"}, 32'(done_count), 32'(target));
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (q.size() < target && n < budget) begin tick(); n++; end
    if (q.size() < target) check_eq({tag, "_beat_timeout"}, 32'(q.size()), 32'(target));
  endtask

  task automatic verify_frame(input int base, input string tag);
    for (int i = 0; i < N; i++) begin
      if (base + i >= q.size()) begin
        check_eq($sformatf("%s_missing%0d", tag, i), 32'(q.size()), 32'(base + N));
        return;
      end
      check_eq($sformatf("%s_data%0d", tag, i), 32'(q[base+i].data), 32'(grey_lut[mem[i]]));
      check_eq($sformatf("%s_sof%0d", tag, i), 32'(q[base+i].sof), 32'(i == 0));
      check_eq($sformatf("%s_eol%0d", tag, i), 32'(q[base+i].eol), 32'(i % W == W - 1));
      check_eq($sformatf("%s_eof%0d", tag, i), 32'(q[base+i].eof), 32'(i == N - 1));
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < N; i++) mem[i] = 2'(i % 4);

    repeat (3) tick();
    check_eq("rst_valid", 32'(m.valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_x", pix_x, 32'd0);
    check_eq("rst_y", pix_y, 32'd0);
    check_eq("rst_data", 32'(m.data), 32'd0);
    check_eq("rst_marks", 32'({m.sof, m.eol, m.eof}), 32'd0);
    rst_n = 1'b1;

    // Full frame, ready always high: latency, marker placement and done timing.
    pulse_start();
    check_eq("t1_busy_after_start", 32'(busy), 32'd1);
    check_eq("t1_valid_after_start", 32'(m.valid), 32'd0);
    tick();
    check_eq("t1_first_valid", 32'(m.valid), 32'd1);
    check_eq("t1_first_sof", 32'(m.sof), 32'd1);
    check_eq("t1_first_data", 32'(m.data), 32'(grey_lut[mem[0]]));
    wait_done(1, 100, "t1");
    repeat (3) tick();
    check_eq("t1_count", 32'(q.size()), 32'd12);
    verify_frame(0, "t1");
    if (q.size() == N) begin
      check_eq("t1_back_to_back", 32'(q[N-1].cyc - q[0].cyc), 32'd11);
      check_eq("t1_done_latency", 32'(done_cyc - q[N-1].cyc), 32'd1);
    end
    check_eq("t1_done_count", 32'(done_count), 32'd1);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // Different code pattern, every grey level present.
    q.delete();
    mem = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    pulse_start();
    wait_done(2, 100, "t2");
    check_eq("t2_count", 32'(q.size()), 32'd12);
    verify_frame(0, "t2");

    // Random back-pressure.
    q.delete();
    rand_mode = 1'b1;
    pulse_start();
    wait_done(3, 400, "t3");
    rand_mode = 1'b0;
    check_eq("t3_count", 32'(q.size()), 32'd12);
    verify_frame(0, "t3");

    // A second start mid-frame is ignored.
    q.delete();
    pulse_start();
    wait_beats(5, 100, "t4");
    pulse_start();
    wait_done(4, 100, "t4");
    repeat (6) tick();
    check_eq("t4_count", 32'(q.size()), 32'd12);
    check_eq("t4_done_count", 32'(done_count), 32'd4);
    check_eq("t4_idle_busy", 32'(busy), 32'd0);
    verify_frame(0, "t4");

    // Reset mid-frame aborts, then a fresh frame runs cleanly.
    q.delete();
    pulse_start();
    wait_beats(6, 100, "t5");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t5_valid", 32'(m.valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_x", pix_x, 32'd0);
    check_eq("t5_y", pix_y, 32'd0);
    q.delete();
    pulse_start();
    wait_done(5, 100, "t5");
    check_eq("t5_count", 32'(q.size()), 32'd12);
    verify_frame(0, "t5");

    // Start held high: two back-to-back frames.
    q.delete();
    base = done_count;
    tick();
    start = 1'b1;
    wait_done(base + 1, 100, "t6a");
    for (int n = 0; n < 10 && !busy; n++) tick();
    start = 1'b0;
    check_eq("t6_rebusy", 32'(busy), 32'd1);
    wait_done(base + 2, 100, "t6b");
    repeat (4) tick();
    check_eq("t6_count", 32'(q.size()), 32'd24);
    check_eq("t6_done_count", 32'(done_count), 32'(base + 2));
    verify_frame(0, "t6f0");
    verify_frame(N, "t6f1");
    if (q.size() == 2 * N) check_eq("t6_gap", 32'(q[N].cyc - q[N-1].cyc), 32'd4);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
